// File: rtl/mult_const_seq.sv
// Sequential matrix-by-scalar multiplier: latches an N x N matrix and a constant on start,
// then produces LANES wrapped or saturated products per clock with per-element overflow flags.
module mult_const_seq #(
    parameter int N     = 5,
    parameter int EW    = 8,
    parameter int LANES = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                signed_mode,
    input  logic                saturate,
    input  logic [N*N*EW-1:0]   matriz_A,
    input  logic [EW-1:0]       const_val,
    output logic [N*N*EW-1:0]   resultado,
    output logic [N*N-1:0]      ovf_mask,
    output logic                overflow,
    output logic                busy,
    output logic                done
);

    localparam int NE  = N * N;
    localparam int NCH = (NE + LANES - 1) / LANES;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    // Two extension bits keep both signed and unsigned EW x EW products exact.
    localparam int PW  = 2 * EW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [NE*EW-1:0]  a_q;
    logic [EW-1:0]     k_q;
    logic              sgn_q;
    logic              sat_q;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              last;
    logic [EW-1:0]     lane_val [LANES];
    logic [LANES-1:0]  lane_ovf;

    // Returns {overflow, element} for a full-precision product.
    function automatic logic [EW:0] sat_elem(input logic signed [PW-1:0] p,
                                             input logic sgn, input logic sat);
        logic          ovf;
        logic [EW-1:0] val;
        if (sgn)
            ovf = !((&p[PW-1:EW-1]) || !(|p[PW-1:EW-1]));
        else
            ovf = |p[PW-1:EW];
        val = p[EW-1:0];
        if (ovf && sat) begin
            if (sgn)
                val = p[PW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
            else
                val = '1;
        end
        return {ovf, val};
    endfunction

    function automatic logic [EW:0] mul_elem(input logic [EW-1:0] a, input logic [EW-1:0] k,
                                             input logic sgn, input logic sat);
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] k_ext;
        logic signed [PW-1:0] p;
        a_ext = {{(PW-EW){sgn & a[EW-1]}}, a};
        k_ext = {{(PW-EW){sgn & k[EW-1]}}, k};
        p     = a_ext * k_ext;
        return sat_elem(p, sgn, sat);
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(NCH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Lanes past the last element read element 0 and have their overflow masked off.
    always_comb begin
        int          idx;
        logic [EW:0] res;
        lane_ovf = '0;
        for (int l = 0; l < LANES; l++) begin
            idx         = int'(cnt) * LANES + l;
            res         = mul_elem(a_q[((idx < NE) ? idx : 0)*EW +: EW], k_q, sgn_q, sat_q);
            lane_val[l] = res[EW-1:0];
            lane_ovf[l] = res[EW] && (idx < NE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            k_q       <= '0;
            sgn_q     <= 1'b0;
            sat_q     <= 1'b0;
            cnt       <= '0;
            resultado <= '0;
            ovf_mask  <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q       <= matriz_A;
            k_q       <= const_val;
            sgn_q     <= signed_mode;
            sat_q     <= saturate;
            cnt       <= '0;
            resultado <= '0;
            ovf_mask  <= '0;
            overflow  <= 1'b0;
        end else if (state == RUN) begin
            cnt <= last ? '0 : cnt + CW'(1);
            for (int e = 0; e < NE; e++) begin
                if (CW'(e / LANES) == cnt) begin
                    resultado[e*EW +: EW] <= lane_val[e % LANES];
                    ovf_mask[e]           <= lane_ovf[e % LANES];
                end
            end
            overflow <= overflow | (|lane_ovf);
        end
    end

endmodule

// File: tb/tb_mult_const_seq.sv
// Directed bench for mult_const_seq: a LANES=5 and a LANES=4 instance share operand inputs
// but have separate start lines.
module tb_mult_const_seq;

    logic         clk;
    logic         rst_n;
    logic         start5, start4;
    logic         signed_mode, saturate;
    logic [199:0] matriz_A;
    logic [7:0]   const_val;
    logic [199:0] res5, res4;
    logic [24:0]  mask5, mask4;
    logic         ovf5, ovf4, busy5, busy4, done5, done4;

    int n_assert;
    int n_fail;
    int cyc, bcnt;
    logic [199:0] m, exp_r;

    mult_const_seq #(.N(5), .EW(8), .LANES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .signed_mode(signed_mode),
        .saturate(saturate), .matriz_A(matriz_A), .const_val(const_val),
        .resultado(res5), .ovf_mask(mask5), .overflow(ovf5), .busy(busy5), .done(done5));

    mult_const_seq #(.N(5), .EW(8), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode),
        .saturate(saturate), .matriz_A(matriz_A), .const_val(const_val),
        .resultado(res4), .ovf_mask(mask4), .overflow(ovf4), .busy(busy4), .done(done4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] r;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Pulses start, then counts edges until done; busy samples are counted along the way.
    task automatic run(input bit use4, output int c, output int b);
        if (use4) start4 = 1'b1; else start5 = 1'b1;
        tick();
        start4 = 1'b0;
        start5 = 1'b0;
        c = 0;
        b = 0;
        while (c < 40) begin
            if (use4 ? busy4 : busy5) b++;
            tick();
            c++;
            if (use4 ? done4 : done5) break;
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst_n = 1'b0; start5 = 1'b0; start4 = 1'b0;
        signed_mode = 1'b0; saturate = 1'b0; matriz_A = '0; const_val = '0;
        repeat (2) tick();
        check("rst_res5", res5, '0);
        check("rst_mask5", mask5, '0);
        check("rst_ovf5", ovf5, 0);
        check("rst_busy5", busy5, 0);
        check("rst_done5", done5, 0);
        check("rst_res4", res4, '0);
        check("rst_busy4", busy4, 0);
        rst_n = 1'b1;
        tick();

        // unsigned wrap, 3 * 4
        matriz_A = fill(8'd3); const_val = 8'd4;
        run(0, cyc, bcnt);
        check("a_cycles", cyc, 5);
        check("a_busy_cycles", bcnt, 5);
        check("a_res", res5, fill(8'h0C));
        check("a_mask", mask5, '0);
        check("a_ovf", ovf5, 0);
        tick();
        check("a_done_pulse", done5, 0);
        check("a_res_stable", res5, fill(8'h0C));

        // unsigned saturate then wrap, element 0 = 200, const 2
        m = fill(8'd1); m[7:0] = 8'd200;
        matriz_A = m; const_val = 8'd2; saturate = 1'b1;
        run(0, cyc, bcnt);
        exp_r = fill(8'd2); exp_r[7:0] = 8'hFF;
        check("b_sat_res", res5, exp_r);
        check("b_sat_mask", mask5, 200'h1);
        check("b_sat_ovf", ovf5, 1);
        saturate = 1'b0;
        run(0, cyc, bcnt);
        exp_r[7:0] = 8'h90;
        check("b_wrap_res", res5, exp_r);
        check("b_wrap_mask", mask5, 200'h1);
        check("b_wrap_ovf", ovf5, 1);

        // signed saturate: -100, 100, -1, 0 times 2
        m = '0; m[7:0] = 8'h9C; m[15:8] = 8'h64; m[23:16] = 8'hFF;
        matriz_A = m; const_val = 8'd2; signed_mode = 1'b1; saturate = 1'b1;
        run(0, cyc, bcnt);
        exp_r = '0; exp_r[7:0] = 8'h80; exp_r[15:8] = 8'h7F; exp_r[23:16] = 8'hFE;
        check("c_res", res5, exp_r);
        check("c_mask", mask5, 200'h3);
        check("c_ovf", ovf5, 1);
        m = '0; m[7:0] = 8'h80;
        matriz_A = m; const_val = 8'hFF;
        run(0, cyc, bcnt);
        exp_r = '0; exp_r[7:0] = 8'h7F;
        check("c_neg_res", res5, exp_r);
        check("c_neg_mask", mask5, 200'h1);
        check("c_neg_ovf", ovf5, 1);

        // LANES=4: seven chunks, last chunk holds element 24 only
        for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i);
        matriz_A = m; const_val = 8'd3; signed_mode = 1'b0; saturate = 1'b0;
        for (int i = 0; i < 25; i++) exp_r[i*8 +: 8] = 8'(3 * i);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("d_busy", busy4, 1);
        repeat (6) tick();
        check("d_el24_pending", res4[199:192], 8'h00);
        check("d_el23", res4[191:184], 8'h45);
        check("d_no_early_done", done4, 0);
        tick();
        check("d_done", done4, 1);
        check("d_res", res4, exp_r);
        check("d_mask", mask4, '0);
        check("d_ovf", ovf4, 0);

        // start pulsed during RUN with other operands is ignored
        matriz_A = fill(8'd3); const_val = 8'd4;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        tick();
        matriz_A = fill(8'd7); const_val = 8'd9; signed_mode = 1'b1; saturate = 1'b1;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        check("e_busy", busy5, 1);
        tick();
        tick();
        check("e_no_early_done", done5, 0);
        tick();
        check("e_done", done5, 1);
        check("e_res", res5, fill(8'h0C));
        check("e_mask", mask5, '0);

        // start held through DONE: back-to-back, flags cleared at re-accept
        m = '0; m[7:0] = 8'h80;
        matriz_A = m; const_val = 8'hFF; signed_mode = 1'b1; saturate = 1'b1;
        start5 = 1'b1;
        tick();
        repeat (5) tick();
        check("f_done1", done5, 1);
        check("f_ovf1", ovf5, 1);
        matriz_A = fill(8'd3); const_val = 8'd4; signed_mode = 1'b0; saturate = 1'b0;
        tick();
        start5 = 1'b0;
        check("f_reaccept_busy", busy5, 1);
        check("f_reaccept_done", done5, 0);
        check("f_ovf_cleared", ovf5, 0);
        check("f_mask_cleared", mask5, '0);
        check("f_res_cleared", res5, '0);
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (done5) break;
        end
        check("f_b2b_gap", cyc + 1, 6);
        check("f_res2", res5, fill(8'h0C));

        // asynchronous reset during chunk 2
        m = fill(8'd1); m[7:0] = 8'd200;
        matriz_A = m; const_val = 8'd2; saturate = 1'b1;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        tick();
        tick();
        check("g_ovf_before", ovf5, 1);
        check("g_busy_before", busy5, 1);
        rst_n = 1'b0;
        #1;
        check("g_rst_res", res5, '0);
        check("g_rst_mask", mask5, '0);
        check("g_rst_ovf", ovf5, 0);
        check("g_rst_busy", busy5, 0);
        check("g_rst_done", done5, 0);
        tick();
        check("g_rst_hold_done", done5, 0);
        rst_n = 1'b1;
        tick();
        matriz_A = fill(8'd3); const_val = 8'd4; saturate = 1'b0;
        run(0, cyc, bcnt);
        check("g_after_cycles", cyc, 5);
        check("g_after_res", res5, fill(8'h0C));
        check("g_after_ovf", ovf5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
